// File: rtl/spi_slave_dev_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_dev_if
// Purpose  : SPI pin bundle plus byte-level host side for spi_slave_dev
// Revision : 1.0
// ============================================================================
interface spi_slave_dev_if;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       underrun;
    logic       frame_err;

    modport slave (
        input  sclk, mosi, cs_n, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
    );

    modport master (
        output sclk, mosi, cs_n, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_dev.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_dev
// Purpose  : SPI mode-0 slave, 8-bit MSB-first, fully oversampled in clk domain
// Revision : 1.0
// ============================================================================
module spi_slave_dev #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'hFF
) (
    input  wire            clk,
    input  wire            rst_n,
    spi_slave_dev_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic                   r_sclk_d;
    logic                   r_csn_d;

    logic [7:0]             r_shift_tx;
    logic [6:0]             r_shift_rx;
    logic [2:0]             r_bit_cnt;
    logic                   r_load_pending;
    logic [7:0]             r_hold;
    logic                   r_hold_full;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic                   r_frame_err;

    logic                   w_sclk_s;
    logic                   w_csn_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_load;
    logic                   w_shift_rx;
    logic                   w_shift_tx;
    logic                   w_end_frame;
    logic                   w_byte_done;
    logic [7:0]             w_load_byte;
    logic [7:0]             w_rx_next;

    // cs_n chain resets low so a cs_n already low at release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_csn_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  bus.cs_n};
            r_sclk_d    <= w_sclk_s;
            r_csn_d     <= w_csn_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_rise   =  w_csn_s  & ~r_csn_d;
    assign w_cs_fall   = ~w_csn_s  &  r_csn_d;

    assign w_load_byte = r_hold_full ? r_hold : TX_IDLE;
    assign w_rx_next   = {r_shift_rx, w_mosi_s};
    assign w_byte_done = w_shift_rx && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Deselect outranks any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift_rx   = 1'b0;
        w_shift_tx   = 1'b0;
        w_end_frame  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_SHIFT;
                    w_load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_end_frame  = 1'b1;
                end else begin
                    w_shift_rx = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_load     = r_load_pending;
                        w_shift_tx = ~r_load_pending;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_tx     <= 8'h00;
            r_shift_rx     <= 7'h00;
            r_bit_cnt      <= 3'd0;
            r_load_pending <= 1'b0;
            r_hold         <= 8'h00;
            r_hold_full    <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_underrun     <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_load) begin
                r_shift_tx     <= w_load_byte;
                r_load_pending <= 1'b0;
                if (!r_hold_full) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_shift_tx) begin
                r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end

            if (w_shift_rx) begin
                r_shift_rx <= w_rx_next[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_rx_data      <= w_rx_next;
                    r_rx_valid     <= 1'b1;
                    r_load_pending <= 1'b1;
                end
            end

            if (w_end_frame) begin
                r_bit_cnt      <= 3'd0;
                r_load_pending <= 1'b0;
                if (r_bit_cnt != 3'd0) begin
                    r_frame_err <= 1'b1;
                end
            end

            // A boundary load empties the hold before any new capture is allowed.
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (bus.tx_valid && !r_hold_full) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign bus.miso      = (r_state == ST_SHIFT) ? r_shift_tx[7] : 1'b0;
    assign bus.miso_oe   = (r_state == ST_SHIFT);
    assign bus.busy      = (r_state == ST_SHIFT);
    assign bus.tx_ready  = ~r_hold_full;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.underrun  = r_underrun;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire
